// File: rtl/mitchell_antilog.sv
// Mitchell antilog: rebuilds 2^k*(1+f/2^WIDTH_F) by shifting one bit per cycle; result after k+1 cycles
// (1 for zero/overflow). Result is held with out_valid until out_ready; new operands accepted only when idle.
module mitchell_antilog #(
    parameter int WIDTH_I = 16,
    parameter int WIDTH_F = WIDTH_I - 1,
    parameter int WIDTH_L = $clog2(2 * WIDTH_I),
    parameter int WIDTH_O = 2 * WIDTH_I,
    parameter int KMAX    = 2 * WIDTH_I - 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_zero,
    input  logic [WIDTH_L-1:0] in_char,
    input  logic [WIDTH_F-1:0] in_frac,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_O-1:0] out,
    output logic               out_ovf
);

    localparam int ACC_W = WIDTH_F + 1 + KMAX;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH_L-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_zero) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else if (in_char > WIDTH_L'(KMAX)) begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        // Hidden leading one restored above the fraction.
                        acc_d   = {{KMAX{1'b0}}, 1'b1, in_frac};
                        cnt_d   = in_char;
                        ovf_d   = 1'b0;
                        state_d = (in_char == '0) ? DONE : SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_q << 1;
                cnt_d = cnt_q - WIDTH_L'(1);
                if (cnt_q == WIDTH_L'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_ovf   = ovf_q;
    // Dropping the low WIDTH_F bits floors away the fractional part.
    assign out       = ovf_q ? {WIDTH_O{1'b1}} : WIDTH_O'(acc_q >> WIDTH_F);

endmodule

// File: tb/tb_mitchell_antilog.sv
// Directed and round-trip checks for mitchell_antilog at WIDTH_I=16.
module tb_mitchell_antilog;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_zero;
    logic [4:0]  in_char;
    logic [14:0] in_frac;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        out_ovf;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mitchell_antilog #(.WIDTH_I(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_zero   (in_zero),
        .in_char   (in_char),
        .in_frac   (in_frac),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_ovf   (out_ovf)
    );

    // Issue one operation starting at a negedge while idle, measure latency in
    // cycles from the accept edge, capture the result and complete the handshake.
    task automatic do_op(input logic z, input logic [4:0] k, input logic [14:0] f,
                         output int lat, output logic [31:0] res, output logic ovf);
        in_valid = 1'b1;
        in_zero  = z;
        in_char  = k;
        in_frac  = f;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_zero  = 1'b0;
        in_char  = '0;
        in_frac  = '0;
        lat = -1;
        res = 32'hDEAD_BEEF;
        ovf = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            if (c > 1) @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = c;
                res = out;
                ovf = out_ovf;
                break;
            end
        end
        if (lat > 0) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_zero   = 1'b0;
        in_char   = '0;
        in_frac   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL reset_held: in_ready=%b out_valid=%b, expected 0 0", in_ready, out_valid);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 32'h0 || out_ovf !== 1'b0)
            $display("FAIL reset_released: in_ready=%b out_valid=%b out=%h ovf=%b, expected 1 0 00000000 0",
                     in_ready, out_valid, out, out_ovf);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int          ks[5]    = '{0, 2, 3, 1, 30};
        int          fs[5]    = '{0, 'h2000, 'h4000, 'h6000, 'h7FFF};
        logic [31:0] exp_o[5] = '{32'd1, 32'd5, 32'd12, 32'd3, 32'h7FFF_8000};
        int          lat;
        logic [31:0] res;
        logic        ovf;
        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, 5'(ks[i]), 15'(fs[i]), lat, res, ovf);
            total++;
            if (res !== exp_o[i] || ovf !== 1'b0)
                $display("FAIL basic_value k=%0d f=%h: out=%h ovf=%b, expected out=%h ovf=0",
                         ks[i], fs[i], res, ovf, exp_o[i]);
            else passed++;
            total++;
            if (lat != ks[i] + 1)
                $display("FAIL basic_latency k=%0d: latency=%0d, expected %0d", ks[i], lat, ks[i] + 1);
            else passed++;
        end
    endtask

    task automatic test_special();
        int          lat;
        logic [31:0] res;
        logic        ovf;
        do_op(1'b0, 5'd31, 15'h1234, lat, res, ovf);
        total++;
        if (res !== 32'hFFFF_FFFF || ovf !== 1'b1 || lat != 1)
            $display("FAIL overflow: out=%h ovf=%b latency=%0d, expected FFFFFFFF 1 1", res, ovf, lat);
        else passed++;
        do_op(1'b1, 5'd7, 15'h5555, lat, res, ovf);
        total++;
        if (res !== 32'h0 || ovf !== 1'b0 || lat != 1)
            $display("FAIL zero: out=%h ovf=%b latency=%0d, expected 00000000 0 1", res, ovf, lat);
        else passed++;
    endtask

    task automatic test_backpressure();
        int waited = 0;
        in_valid = 1'b1;
        in_zero  = 1'b0;
        in_char  = 5'd2;
        in_frac  = 15'h2000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        for (int c = 0; c < 5; c++) begin
            total++;
            if (out !== 32'd5 || out_valid !== 1'b1 || in_ready !== 1'b0 || out_ovf !== 1'b0)
                $display("FAIL backpressure_hold cycle %0d: out=%h valid=%b in_ready=%b ovf=%b, expected 00000005 1 0 0",
                         c, out, out_valid, in_ready, out_ovf);
            else passed++;
            in_valid = c[0] ? 1'b0 : 1'b1;
            in_char  = 5'd0;
            in_frac  = 15'h0;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL backpressure_no_accept: out_valid=%b, expected 0", out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [31:0] res;
        logic        ovf;
        logic        seen = 1'b0;
        in_valid = 1'b1;
        in_zero  = 1'b0;
        in_char  = 5'd10;
        in_frac  = 15'h0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0)
            $display("FAIL reset_mid_ready_low: in_ready=%b, expected 0", in_ready);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_mid_ready: in_ready=%b, expected 1", in_ready);
        else passed++;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0)
            $display("FAIL reset_mid_discard: out_valid rose=%b, expected 0", seen);
        else passed++;
        do_op(1'b0, 5'd4, 15'h0, lat, res, ovf);
        total++;
        if (res !== 32'd16 || ovf !== 1'b0 || lat != 5)
            $display("FAIL reset_mid_next: out=%h ovf=%b latency=%0d, expected 00000010 0 5", res, ovf, lat);
        else passed++;
    endtask

    task automatic test_round_trip();
        int          lat;
        logic [31:0] res;
        logic        ovf;
        int          x;
        int          k;
        int          f;
        for (int n = 0; n < 200; n++) begin
            x = int'($urandom_range(1, 65535));
            k = 0;
            for (int b = 0; b < 16; b++) if (x[b]) k = b;
            f = (x - (1 << k)) << (15 - k);
            do_op(1'b0, 5'(k), 15'(f), lat, res, ovf);
            total++;
            if (res !== 32'(x) || ovf !== 1'b0)
                $display("FAIL round_trip x=%h k=%0d f=%h: out=%h ovf=%b, expected out=%h ovf=0",
                         x, k, f, res, ovf, x);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_backpressure();
        test_reset_mid();
        test_round_trip();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule
